tournament_predictor_param: RTL and testbench

//  Parametrised Alpha-21264-style tournament branch predictor; single clock, no internal clock divider.

---
 rtl/tournament_pkg.sv | 26 ++
 rtl/tournament_predictor_param_sat_counter_table.sv | 47 ++++
 rtl/tournament_predictor_param.sv | 157 +++++++++++++++
 tb/tb_tournament_predictor_param.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/tournament_pkg.sv
// Shared constants and saturating-counter helpers for the tournament branch predictor.
package tournament_pkg;

    localparam int unsigned PC_WIDTH_DEF  = 10;
    localparam int unsigned LHT_IDX_W_DEF = 8;
    localparam int unsigned LHIST_W_DEF   = 10;
    localparam int unsigned GHIST_W_DEF   = 10;

    function automatic int unsigned cnt_max(input int unsigned w);
        return (32'd1 << w) - 32'd1;
    endfunction

    // Weakly-not-taken value: just below the MSB threshold.
    function automatic int unsigned weak_nt(input int unsigned w);
        return (32'd1 << (w - 32'd1)) - 32'd1;
    endfunction

    function automatic int unsigned sat_inc(input int unsigned v, input int unsigned max_v);
        return (v >= max_v) ? max_v : v + 32'd1;
    endfunction

    function automatic int unsigned sat_dec(input int unsigned v);
        return (v == 32'd0) ? 32'd0 : v - 32'd1;
    endfunction

endpackage

// File: rtl/tournament_predictor_param_sat_counter_table.sv
// Table of saturating counters: one combinational read port plus one read-modify-write port.
module sat_counter_table
    import tournament_pkg::*;
#(
    parameter int unsigned IDX_W = 10,
    parameter int unsigned CNT_W = 2,
    parameter int unsigned INIT  = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [IDX_W-1:0] rd_idx_i,
    output logic [CNT_W-1:0] rd_cnt_o,
    input  logic             upd_en_i,
    input  logic [IDX_W-1:0] upd_idx_i,
    input  logic             upd_inc_i,
    output logic [CNT_W-1:0] upd_cnt_o
);

    localparam int unsigned DEPTH = 32'd1 << IDX_W;
    localparam int unsigned MAX   = cnt_max(CNT_W);

    logic [CNT_W-1:0] cnt_q [DEPTH];
    logic [CNT_W-1:0] cnt_d;

    assign rd_cnt_o  = cnt_q[rd_idx_i];
    assign upd_cnt_o = cnt_q[upd_idx_i];

    always_comb begin
        cnt_d = upd_cnt_o;
        if (upd_inc_i) begin
            cnt_d = CNT_W'(sat_inc(32'(upd_cnt_o), MAX));
        end else begin
            cnt_d = CNT_W'(sat_dec(32'(upd_cnt_o)));
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                cnt_q[i] <= CNT_W'(INIT);
            end
        end else if (upd_en_i) begin
            cnt_q[upd_idx_i] <= cnt_d;
        end
    end

endmodule

// File: rtl/tournament_predictor_param.sv
// Tournament branch predictor: local and global predictors arbitrated by a choice table,
// with registered lookup results and saturating branch/mispredict statistics.
module tournament_predictor_param
    import tournament_pkg::*;
#(
    parameter int unsigned PC_WIDTH  = PC_WIDTH_DEF,
    parameter int unsigned LHT_IDX_W = LHT_IDX_W_DEF,
    parameter int unsigned LHIST_W   = LHIST_W_DEF,
    parameter int unsigned LCNT_W    = 3,
    parameter int unsigned GHIST_W   = GHIST_W_DEF,
    parameter int unsigned GCNT_W    = 2,
    parameter int unsigned STAT_W    = 32
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                pred_valid_i,
    input  logic [PC_WIDTH-1:0] pred_pc_i,
    output logic                pred_valid_o,
    output logic                pred_taken_o,
    output logic                pred_global_o,
    output logic                pred_misalign_o,
    input  logic                upd_valid_i,
    input  logic [PC_WIDTH-1:0] upd_pc_i,
    input  logic                upd_taken_i,
    input  logic                upd_pred_i,
    output logic [STAT_W-1:0]   stat_branches_o,
    output logic [STAT_W-1:0]   stat_mispred_o
);

    localparam int unsigned LHT_DEPTH = 32'd1 << LHT_IDX_W;

    logic [LHIST_W-1:0]   lht_q [LHT_DEPTH];
    logic [LHIST_W-1:0]   lht_entry_d;
    logic [GHIST_W-1:0]   ghist_q, ghist_d;
    logic                 pred_valid_q, pred_valid_d;
    logic                 pred_taken_q, pred_taken_d;
    logic                 pred_global_q, pred_global_d;
    logic                 pred_misalign_q, pred_misalign_d;
    logic [STAT_W-1:0]    stat_branches_q, stat_branches_d;
    logic [STAT_W-1:0]    stat_mispred_q, stat_mispred_d;

    logic [LHT_IDX_W-1:0] pred_lidx, upd_lidx;
    logic [LHIST_W-1:0]   pred_lhist, upd_lhist;
    logic [LCNT_W-1:0]    lcnt_rd, lcnt_upd;
    logic [GCNT_W-1:0]    gcnt_rd, gcnt_upd;
    logic [GCNT_W-1:0]    chc_rd, chc_upd;
    logic                 upd_lpred, upd_gpred;
    logic                 chc_train, chc_inc;
    logic                 unused_ok;

    assign pred_lidx  = pred_pc_i[LHT_IDX_W+1:2];
    assign upd_lidx   = upd_pc_i[LHT_IDX_W+1:2];
    assign pred_lhist = lht_q[pred_lidx];
    assign upd_lhist  = lht_q[upd_lidx];

    assign upd_lpred = lcnt_upd[LCNT_W-1];
    assign upd_gpred = gcnt_upd[GCNT_W-1];
    assign chc_train = upd_valid_i && (upd_lpred != upd_gpred);
    assign chc_inc   = (upd_gpred == upd_taken_i);

    sat_counter_table #(.IDX_W(LHIST_W), .CNT_W(LCNT_W), .INIT(weak_nt(LCNT_W))) u_local (
        .clock     (clock),
        .reset     (reset),
        .rd_idx_i  (pred_lhist),
        .rd_cnt_o  (lcnt_rd),
        .upd_en_i  (upd_valid_i),
        .upd_idx_i (upd_lhist),
        .upd_inc_i (upd_taken_i),
        .upd_cnt_o (lcnt_upd)
    );

    sat_counter_table #(.IDX_W(GHIST_W), .CNT_W(GCNT_W), .INIT(weak_nt(GCNT_W))) u_global (
        .clock     (clock),
        .reset     (reset),
        .rd_idx_i  (ghist_q),
        .rd_cnt_o  (gcnt_rd),
        .upd_en_i  (upd_valid_i),
        .upd_idx_i (ghist_q),
        .upd_inc_i (upd_taken_i),
        .upd_cnt_o (gcnt_upd)
    );

    // Choice counter high = trust global; it only moves when the two components disagree.
    sat_counter_table #(.IDX_W(GHIST_W), .CNT_W(GCNT_W), .INIT(weak_nt(GCNT_W))) u_choice (
        .clock     (clock),
        .reset     (reset),
        .rd_idx_i  (ghist_q),
        .rd_cnt_o  (chc_rd),
        .upd_en_i  (chc_train),
        .upd_idx_i (ghist_q),
        .upd_inc_i (chc_inc),
        .upd_cnt_o (chc_upd)
    );

    always_comb begin
        pred_valid_d    = pred_valid_i;
        pred_taken_d    = pred_taken_q;
        pred_global_d   = pred_global_q;
        pred_misalign_d = pred_misalign_q;
        if (pred_valid_i) begin
            pred_global_d   = chc_rd[GCNT_W-1];
            pred_taken_d    = chc_rd[GCNT_W-1] ? gcnt_rd[GCNT_W-1] : lcnt_rd[LCNT_W-1];
            pred_misalign_d = |pred_pc_i[1:0];
        end

        ghist_d         = ghist_q;
        lht_entry_d     = {upd_lhist[LHIST_W-2:0], upd_taken_i};
        stat_branches_d = stat_branches_q;
        stat_mispred_d  = stat_mispred_q;
        if (upd_valid_i) begin
            ghist_d = {ghist_q[GHIST_W-2:0], upd_taken_i};
            if (stat_branches_q != '1) begin
                stat_branches_d = stat_branches_q + STAT_W'(1);
            end
            if ((upd_taken_i != upd_pred_i) && (stat_mispred_q != '1)) begin
                stat_mispred_d = stat_mispred_q + STAT_W'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pred_valid_q    <= 1'b0;
            pred_taken_q    <= 1'b0;
            pred_global_q   <= 1'b0;
            pred_misalign_q <= 1'b0;
            ghist_q         <= '0;
            stat_branches_q <= '0;
            stat_mispred_q  <= '0;
            for (int i = 0; i < int'(LHT_DEPTH); i++) begin
                lht_q[i] <= '0;
            end
        end else begin
            pred_valid_q    <= pred_valid_d;
            pred_taken_q    <= pred_taken_d;
            pred_global_q   <= pred_global_d;
            pred_misalign_q <= pred_misalign_d;
            ghist_q         <= ghist_d;
            stat_branches_q <= stat_branches_d;
            stat_mispred_q  <= stat_mispred_d;
            if (upd_valid_i) begin
                lht_q[upd_lidx] <= lht_entry_d;
            end
        end
    end

    assign pred_valid_o    = pred_valid_q;
    assign pred_taken_o    = pred_taken_q;
    assign pred_global_o   = pred_global_q;
    assign pred_misalign_o = pred_misalign_q;
    assign stat_branches_o = stat_branches_q;
    assign stat_mispred_o  = stat_mispred_q;

    // Counter low bits and PC bits outside the index are intentionally not consumed.
    assign unused_ok = ^{upd_pc_i, pred_pc_i, lcnt_rd, gcnt_rd, chc_rd, chc_upd};

endmodule

// File: tb/tb_tournament_predictor_param.sv
// Randomised bench for tournament_predictor_param against an array-based behavioural model.
module tb_tournament_predictor_param;

    logic        clock = 1'b0;
    logic        reset;
    logic        pred_valid_i;
    logic [9:0]  pred_pc_i;
    logic        pred_valid_o, pred_taken_o, pred_global_o, pred_misalign_o;
    logic        upd_valid_i;
    logic [9:0]  upd_pc_i;
    logic        upd_taken_i, upd_pred_i;
    logic [31:0] stat_branches_o, stat_mispred_o;

    always #5 clock = ~clock;

    tournament_predictor_param dut (
        .clock           (clock),
        .reset           (reset),
        .pred_valid_i    (pred_valid_i),
        .pred_pc_i       (pred_pc_i),
        .pred_valid_o    (pred_valid_o),
        .pred_taken_o    (pred_taken_o),
        .pred_global_o   (pred_global_o),
        .pred_misalign_o (pred_misalign_o),
        .upd_valid_i     (upd_valid_i),
        .upd_pc_i        (upd_pc_i),
        .upd_taken_i     (upd_taken_i),
        .upd_pred_i      (upd_pred_i),
        .stat_branches_o (stat_branches_o),
        .stat_mispred_o  (stat_mispred_o)
    );

    int checks = 0;
    int errors = 0;
    bit cmp_en = 0;

    // Behavioural model: plain arrays of counter values, histories as integers.
    int unsigned m_lht  [256];
    int unsigned m_lcnt [1024];
    int unsigned m_gcnt [1024];
    int unsigned m_chc  [1024];
    int unsigned m_ghist;
    longint unsigned m_br, m_mp;
    bit m_valid, m_taken, m_global, m_mis;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 256; i++) m_lht[i] = 0;
        for (int i = 0; i < 1024; i++) begin
            m_lcnt[i] = 3;
            m_gcnt[i] = 1;
            m_chc[i]  = 1;
        end
        m_ghist = 0;
        m_br = 0; m_mp = 0;
        m_valid = 0; m_taken = 0; m_global = 0; m_mis = 0;
    endfunction

    function automatic bit model_predict(input logic [9:0] pc);
        bit lp, gp;
        lp = m_lcnt[m_lht[pc[9:2]]] >= 4;
        gp = m_gcnt[m_ghist] >= 2;
        return (m_chc[m_ghist] >= 2) ? gp : lp;
    endfunction

    function automatic void model_cycle(input bit pv, input logic [9:0] ppc, input bit uv,
                                        input logic [9:0] upc, input bit ut, input bit up);
        int unsigned h, ul, c;
        bit lp, gp;
        m_valid = pv;
        if (pv) begin
            m_taken  = model_predict(ppc);
            m_global = m_chc[m_ghist] >= 2;
            m_mis    = (ppc[1:0] != 2'b00);
        end
        if (uv) begin
            ul = int'(upc[9:2]);
            h  = m_lht[ul];
            lp = m_lcnt[h] >= 4;
            gp = m_gcnt[m_ghist] >= 2;
            if (lp != gp) begin
                c = m_chc[m_ghist];
                m_chc[m_ghist] = (gp == ut) ? ((c < 3) ? c + 1 : 3) : ((c > 0) ? c - 1 : 0);
            end
            c = m_lcnt[h];
            m_lcnt[h] = ut ? ((c < 7) ? c + 1 : 7) : ((c > 0) ? c - 1 : 0);
            c = m_gcnt[m_ghist];
            m_gcnt[m_ghist] = ut ? ((c < 3) ? c + 1 : 3) : ((c > 0) ? c - 1 : 0);
            m_lht[ul] = ((h << 1) | int'(ut)) & 32'h3FF;
            m_ghist   = ((m_ghist << 1) | int'(ut)) & 32'h3FF;
            if (m_br < 64'hFFFF_FFFF) m_br++;
            if (ut != up && m_mp < 64'hFFFF_FFFF) m_mp++;
        end
    endfunction

    // Single compare process: every cycle after reset release, DUT outputs vs model.
    always @(posedge clock) begin
        #1;
        if (cmp_en) begin
            chk("pred_valid", 64'(pred_valid_o), 64'(m_valid));
            chk("pred_taken", 64'(pred_taken_o), 64'(m_taken));
            chk("pred_global", 64'(pred_global_o), 64'(m_global));
            chk("pred_misalign", 64'(pred_misalign_o), 64'(m_mis));
            chk("stat_branches", 64'(stat_branches_o), m_br);
            chk("stat_mispred", 64'(stat_mispred_o), m_mp);
        end
    end

    task automatic step(input bit pv, input logic [9:0] ppc, input bit uv,
                        input logic [9:0] upc, input bit ut, input bit up);
        @(negedge clock);
        pred_valid_i = pv;
        pred_pc_i    = ppc;
        upd_valid_i  = uv;
        upd_pc_i     = upc;
        // Outcome bits are randomised when no update is requested; they must be ignored.
        upd_taken_i  = uv ? ut : 1'($urandom);
        upd_pred_i   = uv ? up : 1'($urandom);
        model_cycle(pv, ppc, uv, upc, ut, up);
        @(posedge clock);
        #2;
    endtask

    initial begin
        bit t, p;
        logic [9:0] rpc, upc;
        reset        = 1'b0;
        pred_valid_i = 1'b0;
        pred_pc_i    = '0;
        upd_valid_i  = 1'b0;
        upd_pc_i     = '0;
        upd_taken_i  = 1'b0;
        upd_pred_i   = 1'b0;
        model_reset();
        repeat (3) @(posedge clock);
        #1;
        chk("reset_valid", 64'(pred_valid_o), 64'd0);
        chk("reset_taken", 64'(pred_taken_o), 64'd0);
        chk("reset_stat_br", 64'(stat_branches_o), 64'd0);
        chk("reset_stat_mp", 64'(stat_mispred_o), 64'd0);
        @(negedge clock);
        reset  = 1'b1;
        cmp_en = 1;

        step(1, 10'h000, 0, 10'h000, 0, 0);
        chk("first_valid", 64'(pred_valid_o), 64'd1);
        chk("first_taken", 64'(pred_taken_o), 64'd0);
        chk("first_global", 64'(pred_global_o), 64'd0);
        step(0, 10'h000, 0, 10'h000, 0, 0);
        chk("idle_valid", 64'(pred_valid_o), 64'd0);

        for (int i = 0; i < 4; i++) step(0, 10'h000, 1, 10'h010, 1, 0);
        chk("stat_br_4", 64'(stat_branches_o), 64'd4);
        // Twelve taken updates fill the local and global histories with ones and train that entry.
        for (int i = 0; i < 8; i++) step(0, 10'h000, 1, 10'h010, 1, 1);
        step(1, 10'h010, 0, 10'h000, 0, 0);
        chk("trained_taken", 64'(pred_taken_o), 64'd1);
        chk("stat_br_12", 64'(stat_branches_o), 64'd12);

        for (int i = 0; i < 40; i++) begin
            t = (i % 2 == 0);
            p = model_predict(10'h020);
            step(1, 10'h020, 1, 10'h020, t, p);
            if (i >= 30) chk("alt_learned", 64'(pred_taken_o), 64'(t));
        end

        for (int i = 0; i < 3000; i++) begin
            rpc = 10'($urandom_range(0, 255));
            upc = 10'($urandom_range(0, 255));
            step(1'($urandom), rpc, 1'($urandom), upc, ($urandom % 4) != 0, 1'($urandom));
        end

        // Reset while a lookup result is on the outputs.
        @(negedge clock);
        cmp_en       = 0;
        pred_valid_i = 1'b1;
        pred_pc_i    = 10'h010;
        upd_valid_i  = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b0;
        #1;
        chk("midreset_valid", 64'(pred_valid_o), 64'd0);
        chk("midreset_stat_br", 64'(stat_branches_o), 64'd0);
        chk("midreset_stat_mp", 64'(stat_mispred_o), 64'd0);
        pred_valid_i = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        model_reset();
        reset  = 1'b1;
        cmp_en = 1;

        step(1, 10'h010, 0, 10'h000, 0, 0);
        chk("reinit_taken", 64'(pred_taken_o), 64'd0);
        chk("reinit_global", 64'(pred_global_o), 64'd0);

        step(1, 10'h006, 0, 10'h000, 0, 0);
        chk("misalign", 64'(pred_misalign_o), 64'd1);
        for (int i = 0; i < 3; i++) step(0, 10'h000, 1, 10'h006, 0, 1);
        chk("stat_mp_3", 64'(stat_mispred_o), 64'd3);
        chk("stat_br_3", 64'(stat_branches_o), 64'd3);

        step(1, 10'h030, 1, 10'h030, 1, 0);
        chk("same_cycle_taken", 64'(pred_taken_o), 64'd0);
        chk("same_cycle_misalign", 64'(pred_misalign_o), 64'd0);

        for (int i = 0; i < 500; i++) begin
            rpc = 10'($urandom_range(0, 1023));
            upc = 10'($urandom_range(0, 1023));
            step(1'($urandom), rpc, 1'($urandom), upc, 1'($urandom), 1'($urandom));
        end

        cmp_en = 0;
        @(negedge clock);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
